// File: rtl/reg_file_seq.sv
// Self-sequencing register file: reads two operands, waits for the ALU, then writes back.
// Parameters select the data/address widths, the zero-register behaviour and the overflow write-back policy.
module reg_file_seq #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int OVF_MODE = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    input  logic [ADDR_W-1:0] rd2_addr_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              reg_write_i,
    input  logic              alu_valid_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              overflow_i,
    input  logic              clr_ovf_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] rd1_data_o,
    output logic [DATA_W-1:0] rd2_data_o,
    output logic              rd_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_sticky_o,
    output logic [DATA_W-1:0] dbg_data_o
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, READ1, READ2, EXEC, WRITE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [ADDR_W-1:0] rd1_q, rd2_q, wr_q;
    logic              we_q, ovf_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] rd1_data_q, rd2_data_q;
    logic              done_q, sticky_q;
    logic              wr_en;
    logic [DATA_W-1:0] wr_val;
    logic              sticky_set;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = READ1;
            READ1:   state_d = READ2;
            READ2:   state_d = EXEC;
            EXEC:    if (alu_valid_i) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The sticky flag is set on any enabled overflowing write-back, even when the
    // zero register or the hold policy suppresses the actual register update.
    always_comb begin
        wr_en  = (state_q == WRITE) && we_q;
        wr_val = result_q;
        if ((ZERO_REG != 0) && (wr_q == '0)) wr_en = 1'b0;
        if (ovf_q) begin
            if (OVF_MODE == 0)      wr_en  = 1'b0;
            else if (OVF_MODE == 1) wr_val = '1;
        end
        sticky_set = (state_q == WRITE) && we_q && ovf_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= DATA_W'(i);
            rd1_q      <= '0;
            rd2_q      <= '0;
            wr_q       <= '0;
            we_q       <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            rd1_data_q <= '0;
            rd2_data_q <= '0;
            done_q     <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            done_q <= (state_q == WRITE);
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rd1_q <= rd1_addr_i;
                        rd2_q <= rd2_addr_i;
                        wr_q  <= wr_addr_i;
                        we_q  <= reg_write_i;
                    end
                end
                READ1: rd1_data_q <= regs_q[rd1_q];
                READ2: rd2_data_q <= regs_q[rd2_q];
                EXEC: begin
                    if (alu_valid_i) begin
                        result_q <= alu_result_i;
                        ovf_q    <= overflow_i;
                    end
                end
                default: ;
            endcase
            if (wr_en) regs_q[wr_q] <= wr_val;
            if (sticky_set)     sticky_q <= 1'b1;
            else if (clr_ovf_i) sticky_q <= 1'b0;
        end
    end

    assign rd1_data_o   = rd1_data_q;
    assign rd2_data_o   = rd2_data_q;
    assign rd_valid_o   = (state_q == EXEC);
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign ovf_sticky_o = sticky_q;
    assign dbg_data_o   = ((ZERO_REG != 0) && (dbg_addr_i == '0)) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: doc/reg_file_seq.md
Name: reg_file_seq

Overview:
- Parametrised, self-sequencing register file for the microprocessor datapath.
- Generalises the fixed 4x16 state-driven register bank:
  - configurable data width and depth;
  - an internal read/execute/write FSM with a start/done handshake instead of an external state code;
  - a selectable overflow write-back policy and a sticky overflow flag.
- Sits between the control unit (start, addresses, reg_write) and the ALU (operands out, result/overflow in).

Parameters:
- DATA_W, 4: register and ALU data width in bits.
- ADDR_W, 4: register address width; depth = 2**ADDR_W.
- ZERO_REG, 1: 1 = register 0 is hardwired to zero (writes ignored, always reads 0); 0 = register 0 is ordinary.
- OVF_MODE, 0: policy when overflow=1 at write-back.
  - 0 = hold the old value.
  - 1 = saturate to all-ones.
  - 2 = write alu_result regardless.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request one read-execute-write transaction; sampled only in IDLE.
- rd1_addr  in  ADDR_W  first source register; captured on start.
- rd2_addr  in  ADDR_W  second source register; captured on start.
- wr_addr  in  ADDR_W  destination register; captured on start.
- reg_write  in  1  write-back enable; captured on start.
- alu_valid  in  1  ALU result valid; sampled in EXEC.
- alu_result  in  DATA_W  ALU result.
- overflow  in  1  ALU overflow; qualified by alu_valid.
- clr_ovf  in  1  clears ovf_sticky.
- dbg_addr  in  ADDR_W  debug read address.
- rd1_data  out  DATA_W  operand 1 to the ALU.
- rd2_data  out  DATA_W  operand 2 to the ALU.
- rd_valid  out  1  operands valid (high throughout EXEC).
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse after write-back.
- ovf_sticky  out  1  set when overflow is seen at write-back with the write enabled.
- dbg_data  out  DATA_W  combinational read of REG[dbg_addr] (0 for register 0 when ZERO_REG=1).

Behaviour:
- Reset (rst=1 at an edge):
  - REG[i] <= i mod 2**DATA_W for all i.
  - rd1_data, rd2_data, done, ovf_sticky <= 0; state <= IDLE.
  - Reset mid-transaction aborts it: no write occurs and done is not asserted.
- States: IDLE, READ1, READ2, EXEC, WRITE.
  - IDLE: if start=1, capture the addresses and reg_write into internal registers, then go to READ1. Otherwise stay.
  - READ1: rd1_data <= REG[rd1_q]; go to READ2.
  - READ2: rd2_data <= REG[rd2_q]; go to EXEC.
  - EXEC: rd_valid=1. If alu_valid=1, capture alu_result and overflow, then go to WRITE. Otherwise stay; there is no timeout.
  - WRITE: perform the write-back per the rules below; done <= 1 on this edge; go to IDLE.
- Latency: start sampled at edge E0; rd1_data updates at E1; rd2_data at E2; rd_valid is high from E2. With alu_valid present at the first EXEC cycle, the write and done=1 occur at E4.
- Write-back rules, evaluated at the WRITE edge:
  - Write occurs only if reg_write_q=1.
  - If ZERO_REG=1 and wr_q=0: no write; register 0 stays 0.
  - If overflow_q=0: REG[wr_q] <= result_q.
  - If overflow_q=1: apply OVF_MODE (hold / all-ones / result_q).
  - ovf_sticky <= 1 whenever overflow_q=1 and reg_write_q=1, independent of OVF_MODE and of the zero-register rule.
- Flag and pulse timing:
  - clr_ovf clears ovf_sticky at the next edge; a set in the same cycle takes priority.
  - done is high for exactly one cycle; start is accepted during that cycle (state is IDLE).
- start while busy is ignored. Inputs are not re-sampled during a transaction; address changes after start have no effect.
- Reads return the pre-write value. Back-to-back transactions see the previous write because the write precedes the next READ1 by at least one edge.
- Widths: alu_result is exactly DATA_W bits; no extension or truncation is performed.

Test Plan:
- Reset, then dbg_addr sweeps 0..15 (DATA_W=4, ADDR_W=4) -> dbg_data = 0..15; busy=0, done=0.
- start with rd1=3, rd2=5, wr=7, reg_write=1; alu_valid=1 with result=8 at the first EXEC cycle -> rd1_data=3 at E1, rd2_data=5 at E2, done at E4, REG[7]=8.
- wr=0, result=9, ZERO_REG=1 -> REG[0] stays 0, done still pulses. Repeat with ZERO_REG=0 -> REG[0]=9.
- overflow=1, wr=6, result=2, run once per OVF_MODE:
  - mode 0 -> REG[6]=6;
  - mode 1 -> REG[6]=15;
  - mode 2 -> REG[6]=2;
  - all modes -> ovf_sticky=1. Then clr_ovf -> ovf_sticky=0.
- Hold alu_valid=0 for 5 cycles in EXEC -> busy=1, rd_valid=1, no write. Pulse start during this window -> ignored.
- Assert rst during EXEC of a transaction targeting wr=4 -> REG[4]=4, done never pulses, state IDLE. Then a back-to-back pair: write REG[2]=11, second transaction reads rd1=2 -> rd1_data=11.
